// File: rtl/iir_bus_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// iir_bus_scheduler_pkg
// Shared definitions for the IIR register-bus scheduler:
//   - sched_state_e : scheduler FSM states
//   - REG_*         : IIR block register map, including the commit register
//                     and the base of the coefficient region (addr[15]=1)
//   - COEF_STRIDE   : byte stride between consecutive coefficient words
// ----------------------------------------------------------------------------
package iir_bus_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOST_RD = 2'd1,
        ST_LOAD    = 2'd2,
        ST_COMMIT  = 2'd3
    } sched_state_e;

    // IIR register map
    localparam logic [15:0] REG_LOOP            = 16'h0100;
    localparam logic [15:0] REG_SHORTCUT        = 16'h0104;
    localparam logic [15:0] REG_OVERFLOW        = 16'h0108;
    localparam logic [15:0] REG_SET_FILTER      = 16'h0120;
    localparam logic [15:0] REG_IIRBITS         = 16'h0200;
    localparam logic [15:0] REG_IIRSHIFT        = 16'h0204;
    localparam logic [15:0] REG_IIRSTAGES       = 16'h0208;
    localparam logic [15:0] REG_FILTERSTAGES    = 16'h0220;
    localparam logic [15:0] REG_FILTERSHIFTBITS = 16'h0224;
    localparam logic [15:0] REG_FILTERMINBW     = 16'h0228;
    localparam logic [15:0] REG_COEF_BASE       = 16'h8000;

    localparam int COEF_STRIDE = 4;

endpackage

// File: rtl/iir_bus_scheduler_coef_fifo.sv
// ----------------------------------------------------------------------------
// iir_coef_fifo
// Synchronous show-ahead FIFO (DEPTH x DW) buffering coefficient words for
// the load engine. data_o always presents the oldest word while not empty.
//   clk, nreset : clock, asynchronous active-low reset (empties the FIFO)
//   push_i      : write data_i; ignored when full unless a pop happens too
//   data_i      : word to store
//   pop_i       : consume the oldest word; ignored when empty
//   data_o      : oldest word
//   full_o      : DEPTH words stored
//   empty_o     : no words stored
// ----------------------------------------------------------------------------
module iir_coef_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rptr_q];

    // A push into a full FIFO is still taken when the same cycle pops,
    // so occupancy stays at DEPTH.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage is not reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/iir_bus_scheduler.sv
// ----------------------------------------------------------------------------
// iir_bus_scheduler
// Owns the IIR block register bus and shares it between the host control
// port and the coefficient-load engine. The engine streams buffered words
// to COEF_BASE + 4*index and finishes with a write of 1 to SET_FILTER.
//
// Host handshake: the host raises host_req with host_write/host_addr/
// host_wdata and keeps them stable while host_wait=1. A write completes in
// the cycle it is seen with host_wait=0. A read completes in the cycle
// host_rvalid pulses (host_wait=0 there); a request still held in that
// cycle belongs to the finished read and is not restarted.
//
// Ports:
//   clk, nreset                 clock, asynchronous active-low reset
//   host_req/host_write/host_addr/host_wdata  host request
//   host_wait, host_rvalid, host_rdata        host response
//   load_push, load_data, load_full           coefficient FIFO fill port
//   load_start, load_count                    start a load of load_count words
//   load_busy, load_done                      load status
//   iir_addr/iir_wen/iir_ren/iir_wdata/iir_rdata  IIR register bus
// ----------------------------------------------------------------------------
module iir_bus_scheduler
    import iir_bus_scheduler_pkg::*;
#(
    parameter int              AW         = 16,
    parameter int              DW         = 32,
    parameter int              DEPTH      = 8,
    parameter int              RD_LAT     = 2,
    parameter logic [AW-1:0]   COEF_BASE  = AW'(REG_COEF_BASE),
    parameter logic [AW-1:0]   SET_FILTER = AW'(REG_SET_FILTER)
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         host_req,
    input  logic                         host_write,
    input  logic [AW-1:0]                host_addr,
    input  logic [DW-1:0]                host_wdata,
    output logic                         host_wait,
    output logic                         host_rvalid,
    output logic [DW-1:0]                host_rdata,
    input  logic                         load_push,
    input  logic [DW-1:0]                load_data,
    output logic                         load_full,
    input  logic                         load_start,
    input  logic [$clog2(DEPTH+1)-1:0]   load_count,
    output logic                         load_busy,
    output logic                         load_done,
    output logic [AW-1:0]                iir_addr,
    output logic                         iir_wen,
    output logic                         iir_ren,
    output logic [DW-1:0]                iir_wdata,
    input  logic [DW-1:0]                iir_rdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(RD_LAT + 1);

    sched_state_e  state_q;
    logic [RW-1:0] rd_cnt_q;
    logic          pend_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx_q;
    logic          host_rvalid_q;
    logic [DW-1:0] host_rdata_q;
    logic          load_done_q;

    logic          host_new;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;

    iir_coef_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .push_i  (load_push),
        .data_i  (load_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (load_full),
        .empty_o (fifo_empty)
    );

    // During the rvalid cycle the host is still holding the finished read.
    assign host_new  = host_req && !host_rvalid_q;
    assign fifo_pop  = (state_q == ST_LOAD) && !fifo_empty;
    assign load_busy = pend_q || (state_q == ST_LOAD) || (state_q == ST_COMMIT);

    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign load_done   = load_done_q;

    // Bus drive: exactly one requester owns the bus per state, so wen and
    // ren can never be high together.
    always_comb begin
        iir_wen   = 1'b0;
        iir_ren   = 1'b0;
        iir_addr  = '0;
        iir_wdata = '0;
        host_wait = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_new) begin
                    if (host_write) begin
                        iir_wen   = 1'b1;
                        iir_addr  = host_addr;
                        iir_wdata = host_wdata;
                    end else begin
                        host_wait = 1'b1;
                    end
                end
            end
            ST_HOST_RD: begin
                iir_ren   = 1'b1;
                iir_addr  = host_addr;
                host_wait = 1'b1;
            end
            ST_LOAD: begin
                host_wait = host_req;
                if (fifo_pop) begin
                    iir_wen   = 1'b1;
                    iir_addr  = COEF_BASE + (AW'(idx_q) << 2);
                    iir_wdata = fifo_data;
                end
            end
            ST_COMMIT: begin
                host_wait = host_req;
                iir_wen   = 1'b1;
                iir_addr  = SET_FILTER;
                iir_wdata = DW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= ST_IDLE;
            rd_cnt_q      <= '0;
            pend_q        <= 1'b0;
            cnt_q         <= '0;
            idx_q         <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            load_done_q   <= 1'b0;
        end else begin
            host_rvalid_q <= 1'b0;
            load_done_q   <= 1'b0;

            // A start while busy is dropped; pend_q is never cleared in the
            // same cycle a new start is accepted because pend_q implies busy.
            if (load_start && !load_busy) begin
                pend_q <= 1'b1;
                cnt_q  <= load_count;
            end

            case (state_q)
                ST_IDLE: begin
                    if (host_new) begin
                        if (!host_write) begin
                            rd_cnt_q <= '0;
                            state_q  <= ST_HOST_RD;
                        end
                    end else if (pend_q) begin
                        pend_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= (cnt_q == '0) ? ST_COMMIT : ST_LOAD;
                    end
                end
                ST_HOST_RD: begin
                    if (rd_cnt_q == RW'(RD_LAT - 1)) begin
                        host_rdata_q  <= iir_rdata;
                        host_rvalid_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + RW'(1);
                    end
                end
                ST_LOAD: begin
                    if (fifo_pop) begin
                        idx_q <= idx_q + CW'(1);
                        if (idx_q + CW'(1) == cnt_q) begin
                            state_q <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    load_done_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_bus_scheduler.sv
// ----------------------------------------------------------------------------
// tb_iir_bus_scheduler
// Bench for iir_bus_scheduler. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge. A monitor logs every bus
// write; the reference model is a queue of pushed coefficient words from
// which the expected write list (address, data) is computed.
// ----------------------------------------------------------------------------
module tb_iir_bus_scheduler;

    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int DEPTH  = 8;
    localparam int RD_LAT = 2;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] COEF_BASE  = 16'h8000;
    localparam logic [AW-1:0] SET_FILTER = 16'h0120;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          host_req = 1'b0, host_write = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_wait, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          load_push = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_full;
    logic          load_start = 1'b0;
    logic [CW-1:0] load_count = '0;
    logic          load_busy, load_done;
    logic [AW-1:0] iir_addr;
    logic          iir_wen, iir_ren;
    logic [DW-1:0] iir_wdata;
    logic [DW-1:0] iir_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [DW-1:0] fifo_model[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int            log_cyc[$];
    int            both_en = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;

    iir_bus_scheduler #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT),
        .COEF_BASE(COEF_BASE), .SET_FILTER(SET_FILTER)
    ) dut (
        .clk(clk), .nreset(nreset),
        .host_req(host_req), .host_write(host_write), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_wait(host_wait), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .load_push(load_push), .load_data(load_data),
        .load_full(load_full), .load_start(load_start), .load_count(load_count),
        .load_busy(load_busy), .load_done(load_done), .iir_addr(iir_addr),
        .iir_wen(iir_wen), .iir_ren(iir_ren), .iir_wdata(iir_wdata),
        .iir_rdata(iir_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- bus monitor ----------------
    always @(negedge clk) begin
        if (iir_wen === 1'b1) begin
            log_addr.push_back(iir_addr);
            log_data.push_back(iir_wdata);
            log_cyc.push_back(cyc);
        end
        if (iir_wen === 1'b1 && iir_ren === 1'b1) both_en++;
        if (load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        exp_addr_q.delete();
        exp_q.delete();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        load_push = 1'b1;
        load_data = w;
        if (fifo_model.size() < DEPTH) fifo_model.push_back(w);
        tick();
        load_push = 1'b0;
    endtask

    // Expected writes of an n-word load: words in push order to
    // COEF_BASE + 4*i (mod 2^AW), then the commit write.
    task automatic build_expect(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(AW'(COEF_BASE + 4 * i));
            exp_q.push_back(fifo_model.pop_front());
        end
        exp_addr_q.push_back(SET_FILTER);
        exp_q.push_back(DW'(1));
    endtask

    task automatic start_load(input int n);
        load_count = CW'(n);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_count = '0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (load_done === 1'b1) seen = 1'b1;
            else tick();
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: load_done not seen within %0d cycles", name, budget);
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        tests_run++;
        if ({iir_wen, iir_ren, iir_addr, iir_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: got wen=%b ren=%b addr=%h wdata=%h, expected all 0",
                     iir_wen, iir_ren, iir_addr, iir_wdata);
        end
        tests_run++;
        if ({host_wait, host_rvalid, host_rdata, load_full, load_busy, load_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_status: got wait=%b rvalid=%b rdata=%h full=%b busy=%b done=%b, expected all 0",
                     host_wait, host_rvalid, host_rdata, load_full, load_busy, load_done);
        end
        tick();
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_host_write();
        for (int it = 0; it < 4; it++) begin
            logic [AW-1:0] a = (it == 0) ? 16'h0104 : AW'($urandom);
            logic [DW-1:0] d = (it == 0) ? 32'h1 : $urandom;
            host_req = 1'b1; host_write = 1'b1; host_addr = a; host_wdata = d;
            @(negedge clk);
            tests_run++;
            if (iir_wen !== 1'b1 || iir_ren !== 1'b0 || iir_addr !== a || iir_wdata !== d || host_wait !== 1'b0) begin
                tests_failed++;
                $display("FAIL host_write: got wen=%b ren=%b addr=%h wdata=%h wait=%b, expected wen=1 ren=0 addr=%h wdata=%h wait=0",
                         iir_wen, iir_ren, iir_addr, iir_wdata, host_wait, a, d);
            end
            tick();
            host_req = 1'b0; host_write = 1'b0;
            tick();
        end
    endtask

    task automatic test_host_read();
        for (int it = 0; it < 3; it++) begin
            logic [AW-1:0] a = (it == 0) ? 16'h0200 : AW'($urandom);
            logic [DW-1:0] v = (it == 0) ? 32'h0E : $urandom;
            host_req = 1'b1; host_write = 1'b0; host_addr = a; iir_rdata = ~v;
            @(negedge clk);
            tests_run++;
            if (host_wait !== 1'b1 || iir_ren !== 1'b0 || iir_wen !== 1'b0) begin
                tests_failed++;
                $display("FAIL read_accept: got wait=%b ren=%b wen=%b, expected 1 0 0", host_wait, iir_ren, iir_wen);
            end
            tick();
            for (int k = 1; k <= RD_LAT; k++) begin
                // Only the last ren cycle carries the real data.
                iir_rdata = (k == RD_LAT) ? v : ~v;
                @(negedge clk);
                tests_run++;
                if (iir_ren !== 1'b1 || iir_wen !== 1'b0 || iir_addr !== a || host_wait !== 1'b1 || host_rvalid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL read_cycle%0d: got ren=%b wen=%b addr=%h wait=%b rvalid=%b, expected 1 0 %h 1 0",
                             k, iir_ren, iir_wen, iir_addr, host_wait, host_rvalid, a);
                end
                tick();
            end
            iir_rdata = ~v;
            @(negedge clk);
            tests_run++;
            if (host_rvalid !== 1'b1 || host_rdata !== v || host_wait !== 1'b0 || iir_ren !== 1'b0) begin
                tests_failed++;
                $display("FAIL read_result: got rvalid=%b rdata=%h wait=%b ren=%b, expected 1 %h 0 0",
                         host_rvalid, host_rdata, host_wait, iir_ren, v);
            end
            tick();
            host_req = 1'b0;
            @(negedge clk);
            tests_run++;
            if (host_rvalid !== 1'b0 || iir_ren !== 1'b0) begin
                tests_failed++;
                $display("FAIL read_pulse: got rvalid=%b ren=%b after completion, expected 0 0", host_rvalid, iir_ren);
            end
            tick();
        end
    endtask

    task automatic test_load();
        for (int it = 0; it < 4; it++) begin
            int n = (it == 0) ? 3 : (it == 1) ? 0 : $urandom_range(1, DEPTH);
            int bad = 0;
            clear_log();
            for (int i = 0; i < n; i++) push_word($urandom);
            build_expect(n);
            start_load(n);
            wait_done(4 * n + 20, "load_done");
            @(negedge clk);
            tests_run++;
            if (load_done !== 1'b0 || load_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_idle: got done=%b busy=%b after load, expected 0 0", load_done, load_busy);
            end
            tick();
            tests_run++;
            if (log_addr.size() !== exp_addr_q.size()) begin
                tests_failed++;
                $display("FAIL load_count: got %0d writes, expected %0d", log_addr.size(), exp_addr_q.size());
            end else begin
                for (int i = 0; i < exp_addr_q.size(); i++) begin
                    tests_run++;
                    if (log_addr[i] !== exp_addr_q[i] || log_data[i] !== exp_q[i]) begin
                        tests_failed++;
                        $display("FAIL load_write%0d: got %h<=%h, expected %h<=%h",
                                 i, log_addr[i], log_data[i], exp_addr_q[i], exp_q[i]);
                    end
                end
                for (int i = 1; i < log_cyc.size(); i++)
                    if (log_cyc[i] != log_cyc[i-1] + 1) bad++;
                tests_run++;
                if (bad != 0 || done_cyc != log_cyc[log_cyc.size()-1] + 1) begin
                    tests_failed++;
                    $display("FAIL load_timing: got %0d gaps, done at %0d after commit at %0d, expected 0 gaps and done one cycle later",
                             bad, done_cyc, log_cyc[log_cyc.size()-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        clear_log();
        push_word($urandom);
        push_word($urandom);
        start_load(4);
        repeat (3) tick();
        // Ignored: the engine is busy.
        start_load(1);
        repeat (6) tick();
        @(negedge clk);
        tests_run++;
        if (log_addr.size() !== 2 || load_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall: got %0d writes busy=%b, expected 2 writes busy=1", log_addr.size(), load_busy);
        end
        tick();
        push_word($urandom);
        push_word($urandom);
        build_expect(4);
        wait_done(30, "stall_done");
        tests_run++;
        if (log_addr.size() !== exp_addr_q.size()) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d writes, expected %0d", log_addr.size(), exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                tests_run++;
                if (log_addr[i] !== exp_addr_q[i] || log_data[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL stall_write%0d: got %h<=%h, expected %h<=%h",
                             i, log_addr[i], log_data[i], exp_addr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [AW-1:0] ra = AW'($urandom);
        logic [DW-1:0] rv = $urandom;
        logic [AW-1:0] wa = AW'($urandom);
        logic [DW-1:0] wd = $urandom;
        int rv_cyc = -1;
        int bad = 0;
        bit seen = 1'b0;
        clear_log();
        push_word($urandom);
        push_word($urandom);
        build_expect(2);
        exp_addr_q.push_back(wa);
        exp_q.push_back(wd);
        host_req = 1'b1; host_write = 1'b0; host_addr = ra; iir_rdata = rv;
        start_load(2);
        @(negedge clk);
        tests_run++;
        if (load_busy !== 1'b1 || iir_ren !== 1'b1) begin
            tests_failed++;
            $display("FAIL prio_pending: got busy=%b ren=%b, expected 1 1", load_busy, iir_ren);
        end
        tick();
        for (int i = 0; i < 10 && rv_cyc < 0; i++) begin
            @(negedge clk);
            if (host_rvalid === 1'b1) rv_cyc = cyc;
            else tick();
        end
        tests_run++;
        if (rv_cyc < 0) begin
            tests_failed++;
            $display("FAIL prio_rvalid: got no host_rvalid in 10 cycles, expected one");
        end else begin
            tests_run++;
            if (host_rdata !== rv) begin
                tests_failed++;
                $display("FAIL prio_rdata: got %h, expected %h", host_rdata, rv);
            end
        end
        tick();
        host_write = 1'b1; host_addr = wa; host_wdata = wd;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (load_done === 1'b1) begin
                seen = 1'b1;
                tests_run++;
                if (host_wait !== 1'b0 || iir_wen !== 1'b1 || iir_addr !== wa) begin
                    tests_failed++;
                    $display("FAIL prio_host_grant: got wait=%b wen=%b addr=%h, expected 0 1 %h",
                             host_wait, iir_wen, iir_addr, wa);
                end
            end else begin
                if (host_wait !== 1'b1) bad++;
                tick();
            end
        end
        tests_run++;
        if (!seen || bad != 0) begin
            tests_failed++;
            $display("FAIL prio_host_wait: got done_seen=%b and %0d cycles with wait=0, expected 1 and 0", seen, bad);
        end
        tick();
        host_req = 1'b0; host_write = 1'b0;
        tick();
        tests_run++;
        if (log_addr.size() !== exp_addr_q.size()) begin
            tests_failed++;
            $display("FAIL prio_count: got %0d writes, expected %0d", log_addr.size(), exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                tests_run++;
                if (log_addr[i] !== exp_addr_q[i] || log_data[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL prio_write%0d: got %h<=%h, expected %h<=%h",
                             i, log_addr[i], log_data[i], exp_addr_q[i], exp_q[i]);
                end
            end
            tests_run++;
            if (log_cyc[0] != rv_cyc + 1) begin
                tests_failed++;
                $display("FAIL prio_first_write: got cycle %0d, expected %0d", log_cyc[0], rv_cyc + 1);
            end
        end
    endtask

    task automatic test_full_and_reset();
        int done_before;
        clear_log();
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_word($urandom);
            @(negedge clk);
            tests_run++;
            if (load_full !== (fifo_model.size() == DEPTH)) begin
                tests_failed++;
                $display("FAIL full_after_push%0d: got %b, expected %b", i + 1, load_full, fifo_model.size() == DEPTH);
            end
            tick();
        end
        build_expect(DEPTH);
        start_load(DEPTH);
        wait_done(60, "full_done");
        tests_run++;
        if (log_addr.size() !== exp_addr_q.size() || load_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_drain: got %0d writes full=%b, expected %0d writes full=0",
                     log_addr.size(), load_full, exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                tests_run++;
                if (log_addr[i] !== exp_addr_q[i] || log_data[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL full_write%0d: got %h<=%h, expected %h<=%h",
                             i, log_addr[i], log_data[i], exp_addr_q[i], exp_q[i]);
                end
            end
        end

        // Abort a load part-way through.
        clear_log();
        for (int i = 0; i < 4; i++) push_word($urandom);
        start_load(4);
        for (int i = 0; i < 20 && log_addr.size() < 2; i++) tick();
        done_before = done_cnt;
        nreset = 1'b0;
        #1;
        tests_run++;
        if ({iir_wen, iir_ren, iir_addr, iir_wdata, host_wait, host_rvalid, host_rdata,
             load_full, load_busy, load_done} !== '0) begin
            tests_failed++;
            $display("FAIL midload_reset: got wen=%b ren=%b addr=%h wdata=%h busy=%b done=%b, expected all 0",
                     iir_wen, iir_ren, iir_addr, iir_wdata, load_busy, load_done);
        end
        fifo_model.delete();
        tick();
        tick();
        nreset = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (done_cnt != done_before) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d load_done pulses after reset, expected 0", done_cnt - done_before);
        end

        // FIFO must be empty and the index back at 0.
        clear_log();
        start_load(1);
        repeat (5) tick();
        tests_run++;
        if (log_addr.size() !== 0) begin
            tests_failed++;
            $display("FAIL reset_fifo_empty: got %0d writes from an empty FIFO, expected 0", log_addr.size());
        end
        push_word($urandom);
        build_expect(1);
        wait_done(20, "reset_reload_done");
        tests_run++;
        if (log_addr.size() !== 2 || log_addr[0] !== exp_addr_q[0] || log_data[0] !== exp_q[0]
            || log_addr[1] !== exp_addr_q[1] || log_data[1] !== exp_q[1]) begin
            tests_failed++;
            $display("FAIL reset_reload: got %0d writes, first %h<=%h, expected 2 writes, first %h<=%h",
                     log_addr.size(), log_addr.size() > 0 ? log_addr[0] : '0,
                     log_data.size() > 0 ? log_data[0] : '0, exp_addr_q[0], exp_q[0]);
        end
    endtask

    task automatic test_mutex();
        tests_run++;
        if (both_en != 0) begin
            tests_failed++;
            $display("FAIL wen_ren_exclusive: got %0d cycles with both high, expected 0", both_en);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_host_write();
        test_host_read();
        test_load();
        test_stall();
        test_priority();
        test_full_and_reset();
        test_mutex();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
